// File: rtl/dark_uart_if.sv
// Bus-side port group of the UART: qualified strobes, byte enables, data and interrupt.
interface dark_uart_if;
    logic        RD;
    logic        WR;
    logic [3:0]  BE;
    logic [31:0] DATAI;
    logic [31:0] DATAO;
    logic        IRQ;

    modport master (output RD, WR, BE, DATAI, input DATAO, IRQ);
    modport slave  (input RD, WR, BE, DATAI, output DATAO, IRQ);
endinterface

// File: rtl/dark_uart.sv
// 8N1 UART peripheral: one TX shifter, one RX deserialiser with a one-byte holding
// register, and a programmable bit-period divisor, all mapped into a single bus word.
module dark_uart #(
    parameter logic [15:0] BAUD = 16'd434
) (
    input  logic        clk,
    input  logic        rst_n,
    dark_uart_if.slave  bus,
    input  logic        RXD,
    output logic        TXD,
    output logic        FINISH_REQ,
    output logic [3:0]  DEBUG
);
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    tx_state_t   r_tx_state, w_tx_state_next;
    rx_state_t   r_rx_state, w_rx_state_next;

    logic [15:0] r_div;
    logic [15:0] r_tx_cnt, r_tx_per;
    logic [7:0]  r_tx_shift;
    logic [2:0]  r_tx_bit;
    logic        r_txd, r_finish;
    logic        r_rx_meta, r_rx_sync;
    logic [15:0] r_rx_cnt;
    logic [7:0]  r_rx_shift, r_rx_data;
    logic [2:0]  r_rx_bit;
    logic        r_rx_valid, r_ferr, r_ovr;

    logic [15:0] w_period, w_half;
    logic        w_tx_busy, w_tx_start, w_tx_tick;
    logic        w_rx_half_tick, w_rx_tick, w_rx_done, w_rd_clr;
    logic        w_unused;

    assign w_period   = (r_div == 16'd0) ? 16'd1 : r_div;
    assign w_half     = (w_period[15:1] == 15'd0) ? 16'd1 : {1'b0, w_period[15:1]};
    assign w_tx_busy  = (r_tx_state != TX_IDLE);
    assign w_tx_start = bus.WR && bus.BE[1] && !w_tx_busy;
    // Each TX bit runs on the period latched at its start, so DIV writes land on bit boundaries.
    assign w_tx_tick  = (r_tx_cnt == r_tx_per - 16'd1);
    assign w_rx_half_tick = (r_rx_cnt >= w_half - 16'd1);
    assign w_rx_tick  = (r_rx_cnt >= w_period - 16'd1);
    assign w_rx_done  = (r_rx_state == RX_STOP) && w_rx_tick;
    assign w_rd_clr   = bus.RD && bus.BE[1];
    assign w_unused   = ^{bus.BE[0], bus.DATAI[7:0]};

    assign bus.DATAO  = {r_div, r_rx_data, 4'b0000, r_ovr, r_ferr, r_rx_valid, w_tx_busy};
    assign bus.IRQ    = r_rx_valid;
    assign TXD        = r_txd;
    assign FINISH_REQ = r_finish;
    assign DEBUG      = {r_rx_sync, r_txd, w_tx_busy, r_rx_valid};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= TX_IDLE;
            r_rx_state <= RX_IDLE;
        end else begin
            r_tx_state <= w_tx_state_next;
            r_rx_state <= w_rx_state_next;
        end
    end

    always_comb begin
        w_tx_state_next = r_tx_state;
        case (r_tx_state)
            TX_IDLE:  if (w_tx_start) w_tx_state_next = TX_START;
            TX_START: if (w_tx_tick) w_tx_state_next = TX_DATA;
            TX_DATA:  if (w_tx_tick && r_tx_bit == 3'd7) w_tx_state_next = TX_STOP;
            TX_STOP:  if (w_tx_tick) w_tx_state_next = TX_IDLE;
            default:  w_tx_state_next = TX_IDLE;
        endcase
    end

    always_comb begin
        w_rx_state_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE:  if (!r_rx_sync) w_rx_state_next = RX_START;
            RX_START: if (w_rx_half_tick) w_rx_state_next = r_rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_state_next = RX_STOP;
            RX_STOP:  if (w_rx_tick) w_rx_state_next = RX_IDLE;
            default:  w_rx_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= BAUD;
        end else begin
            if (bus.WR && bus.BE[2]) r_div[7:0]  <= bus.DATAI[23:16];
            if (bus.WR && bus.BE[3]) r_div[15:8] <= bus.DATAI[31:24];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_txd      <= 1'b1;
            r_finish   <= 1'b0;
            r_tx_cnt   <= 16'd0;
            r_tx_per   <= 16'd1;
            r_tx_shift <= 8'd0;
            r_tx_bit   <= 3'd0;
        end else begin
            r_finish <= w_tx_start && (bus.DATAI[15:8] == 8'h04);
            if (w_tx_start) begin
                r_txd      <= 1'b0;
                r_tx_shift <= bus.DATAI[15:8];
                r_tx_cnt   <= 16'd0;
                r_tx_per   <= w_period;
                r_tx_bit   <= 3'd0;
            end else if (w_tx_busy) begin
                if (w_tx_tick) begin
                    r_tx_cnt <= 16'd0;
                    r_tx_per <= w_period;
                    case (r_tx_state)
                        TX_START: begin
                            r_txd      <= r_tx_shift[0];
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        end
                        TX_DATA: begin
                            r_txd      <= (r_tx_bit == 3'd7) ? 1'b1 : r_tx_shift[0];
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                            r_tx_bit   <= r_tx_bit + 3'd1;
                        end
                        default: r_txd <= 1'b1;
                    endcase
                end else begin
                    r_tx_cnt <= r_tx_cnt + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_cnt   <= 16'd0;
            r_rx_shift <= 8'd0;
            r_rx_bit   <= 3'd0;
            r_rx_data  <= 8'd0;
            r_rx_valid <= 1'b0;
            r_ferr     <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_rx_meta <= RXD;
            r_rx_sync <= r_rx_meta;
            case (r_rx_state)
                RX_IDLE: begin
                    r_rx_cnt <= 16'd0;
                    r_rx_bit <= 3'd0;
                end
                RX_START: r_rx_cnt <= w_rx_half_tick ? 16'd0 : r_rx_cnt + 16'd1;
                RX_DATA: begin
                    if (w_rx_tick) begin
                        r_rx_cnt   <= 16'd0;
                        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                        r_rx_bit   <= r_rx_bit + 3'd1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 16'd1;
                    end
                end
                default: r_rx_cnt <= r_rx_cnt + 16'd1;
            endcase
            // A completing byte beats a clearing read in the same cycle.
            if (w_rx_done) begin
                r_rx_data  <= r_rx_shift;
                r_rx_valid <= 1'b1;
                r_ferr     <= !r_rx_sync;
                r_ovr      <= r_rx_valid && !w_rd_clr;
            end else if (w_rd_clr) begin
                r_rx_valid <= 1'b0;
                r_ferr     <= 1'b0;
                r_ovr      <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dark_uart.sv
// Directed bench for dark_uart at a 4-cycle bit period: TX framing, busy drop, EOT pulse,
// RX bytes with overrun/framing error, glitch rejection, divisor reload and mid-frame reset.
module tb_dark_uart;
    logic       clk;
    logic       rst_n;
    logic       RXD;
    logic       TXD;
    logic       FINISH_REQ;
    logic [3:0] DEBUG;

    int n_vec;
    int n_err;

    dark_uart_if bus();

    dark_uart #(.BAUD(16'd4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .RXD        (RXD),
        .TXD        (TXD),
        .FINISH_REQ (FINISH_REQ),
        .DEBUG      (DEBUG)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [3:0] be, input logic [31:0] data);
        bus.WR = 1'b1;
        bus.BE = be;
        bus.DATAI = data;
        tick();
        bus.WR = 1'b0;
        bus.BE = 4'b0000;
        bus.DATAI = 32'h0;
    endtask

    task automatic bus_read(input logic [3:0] be);
        bus.RD = 1'b1;
        bus.BE = be;
        tick();
        bus.RD = 1'b0;
        bus.BE = 4'b0000;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        RXD = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            repeat (4) tick();
        end
        RXD = stop_bit;
        repeat (4) tick();
        RXD = 1'b1;
        repeat (8) tick();
    endtask

    task automatic wait_tx_idle(input int budget);
        for (int k = 0; k < budget && bus.DATAO[0]; k++) tick();
        check_vec("tx_idle_wait", {31'd0, bus.DATAO[0]}, 32'd0);
    endtask

    initial begin
        logic [9:0] frame;
        logic       fin_seen;
        int         busy_cycles;

        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        RXD = 1'b1;
        bus.RD = 1'b0;
        bus.WR = 1'b0;
        bus.BE = 4'b0000;
        bus.DATAI = 32'h0;
        repeat (3) tick();

        check_vec("rst_datao", bus.DATAO, 32'h0004_0000);
        check_vec("rst_txd", {31'd0, TXD}, 32'd1);
        check_vec("rst_irq", {31'd0, bus.IRQ}, 32'd0);
        check_vec("rst_debug", {30'd0, DEBUG[1:0]}, 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // TX 0xA5, with a second write of 0x5A mid-frame that must be dropped
        frame = {1'b1, 8'hA5, 1'b0};
        fin_seen = 1'b0;
        bus_write(4'b0010, 32'h0000_A500);
        check_vec("tx_busy_set", {31'd0, bus.DATAO[0]}, 32'd1);
        for (int i = 0; i < 40; i++) begin
            check_vec($sformatf("tx_a5_c%0d", i), {31'd0, TXD}, {31'd0, frame[i/4]});
            fin_seen = fin_seen | FINISH_REQ;
            if (i == 8) begin
                bus.WR = 1'b1;
                bus.BE = 4'b0010;
                bus.DATAI = 32'h0000_5A00;
            end
            tick();
            bus.WR = 1'b0;
            bus.BE = 4'b0000;
            bus.DATAI = 32'h0;
        end
        check_vec("tx_busy_clr", {31'd0, bus.DATAO[0]}, 32'd0);
        check_vec("tx_idle_txd", {31'd0, TXD}, 32'd1);
        check_vec("no_finish", {31'd0, fin_seen}, 32'd0);

        // EOT byte raises a single-cycle finish pulse
        bus_write(4'b0010, 32'h0000_0400);
        check_vec("finish_pulse", {31'd0, FINISH_REQ}, 32'd1);
        tick();
        check_vec("finish_drop", {31'd0, FINISH_REQ}, 32'd0);
        wait_tx_idle(60);

        // RX 0x3C, non-clearing read, clearing read
        send_rx(8'h3C, 1'b1);
        check_vec("rx_3c_data", {24'd0, bus.DATAO[15:8]}, 32'h3C);
        check_vec("rx_3c_status", {24'd0, bus.DATAO[7:0]}, 32'h02);
        check_vec("rx_3c_irq", {31'd0, bus.IRQ}, 32'd1);
        bus_read(4'b0001);
        check_vec("rd_be0_keep", {24'd0, bus.DATAO[7:0]}, 32'h02);
        bus_read(4'b0010);
        check_vec("rd_clr_status", {24'd0, bus.DATAO[7:0]}, 32'h00);
        check_vec("rd_clr_irq", {31'd0, bus.IRQ}, 32'd0);

        // Overrun
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        check_vec("ovr_data", {24'd0, bus.DATAO[15:8]}, 32'h22);
        check_vec("ovr_status", {24'd0, bus.DATAO[7:0]}, 32'h0A);
        bus_read(4'b0010);
        check_vec("ovr_clr", {24'd0, bus.DATAO[7:0]}, 32'h00);

        // Framing error
        send_rx(8'h55, 1'b0);
        check_vec("ferr_data", {24'd0, bus.DATAO[15:8]}, 32'h55);
        check_vec("ferr_status", {24'd0, bus.DATAO[7:0]}, 32'h06);
        bus_read(4'b0010);

        // One-cycle glitch while idle
        RXD = 1'b0;
        tick();
        RXD = 1'b1;
        repeat (50) tick();
        check_vec("glitch_status", {24'd0, bus.DATAO[7:0]}, 32'h00);
        check_vec("glitch_data", {24'd0, bus.DATAO[15:8]}, 32'h55);

        // Divisor reload to 8, frame length 80 cycles
        bus_write(4'b1100, 32'h0008_0000);
        check_vec("div_load", {16'd0, bus.DATAO[31:16]}, 32'h0008);
        check_vec("div_no_tx", {31'd0, bus.DATAO[0]}, 32'd0);
        bus_write(4'b0010, 32'h0000_C300);
        busy_cycles = 0;
        for (int k = 0; k < 200 && bus.DATAO[0]; k++) begin
            busy_cycles++;
            tick();
        end
        check_vec("frame_len_div8", busy_cycles, 32'd80);

        // Asynchronous reset mid-frame
        bus_write(4'b0010, 32'h0000_8100);
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        check_vec("midrst_txd", {31'd0, TXD}, 32'd1);
        check_vec("midrst_datao", bus.DATAO, 32'h0004_0000);
        check_vec("midrst_debug", {28'd0, DEBUG}, 32'hC);
        rst_n = 1'b1;
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
